// File: rtl/osiris_wb_responder.sv
// osiris_wb_responder: Wishbone classic slave terminating the management bus
// for the osiris_i core. It holds a CTRL register and moves 32-bit words
// through two FIFOs: host-to-core (TX) and core-to-host (RX).
//
// Ports
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i     Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]           byte lane selects (used by CTRL writes)
//   wbs_adr_i/dat_i[31:0]    byte address, write data
//   wbs_ack_o, wbs_dat_o     one-cycle acknowledge, read data (0 outside ack)
//   tx_valid_o/data_o/ready_i  TX FIFO head towards the core
//   rx_valid_i/data_i/ready_o  RX FIFO input from the core
//   ctrl_o[31:0]             CTRL register contents
//   irq_o                    registered level interrupt
//
// Register map (adr[3:2]): 0 CTRL, 1 STATUS, 2 TXDATA, 3 RXDATA.
module osiris_wb_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK  = 32'hFFFF_FFF0,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        tx_valid_o,
   output logic [31:0] tx_data_o,
   input  logic        tx_ready_i,
   input  logic        rx_valid_i,
   input  logic [31:0] rx_data_i,
   output logic        rx_ready_o,
   output logic [31:0] ctrl_o,
   output logic        irq_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_TXDATA = 2'd2;
   localparam logic [1:0] OFF_RXDATA = 2'd3;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]   r_rdata;
   logic [31:0]   r_ctrl;
   logic          r_tx_ovf;
   logic          r_rx_udf;
   logic          r_irq;

   logic [31:0]   r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_tx_wp;
   logic [AW-1:0] r_tx_rp;
   logic [CW-1:0] r_tx_cnt;

   logic [31:0]   r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rx_wp;
   logic [AW-1:0] r_rx_rp;
   logic [CW-1:0] r_rx_cnt;

   logic          w_hit;
   logic [1:0]    w_off;
   logic          w_access;
   logic [31:0]   w_rdata_nxt;
   logic [31:0]   w_ctrl_nxt;
   logic          w_flush;
   logic          w_tx_push;
   logic          w_tx_ovf_set;
   logic          w_rx_pop;
   logic          w_rx_udf_set;
   logic [1:0]    w_sts_clr;
   logic          w_tx_pop;
   logic          w_rx_push;
   logic          w_tx_full;
   logic          w_tx_empty;
   logic          w_rx_full;
   logic          w_rx_empty;
   logic [31:0]   w_status;

   // Address decode and FIFO occupancy flags (pre-cycle state)
   assign w_hit      = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
   assign w_off      = wbs_adr_i[3:2];
   assign w_tx_full  = (r_tx_cnt == FULL_CNT);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == FULL_CNT);
   assign w_rx_empty = (r_rx_cnt == '0);

   assign w_status = {8'h00, 8'(r_rx_cnt), 8'(r_tx_cnt), 2'b00,
                      w_rx_empty, w_rx_full, w_tx_empty, w_tx_full,
                      r_rx_udf, r_tx_ovf};

   // Core-side handshakes; flush overrides both in the FIFO update
   assign w_tx_pop  = tx_valid_o & tx_ready_i;
   assign w_rx_push = rx_valid_i & rx_ready_o;

   // FSM state register
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   // Next state and access decode; the access happens in IDLE, ack follows
   always_comb begin
      w_state_nxt  = r_state;
      w_access     = 1'b0;
      w_rdata_nxt  = '0;
      w_ctrl_nxt   = r_ctrl;
      w_flush      = 1'b0;
      w_tx_push    = 1'b0;
      w_tx_ovf_set = 1'b0;
      w_rx_pop     = 1'b0;
      w_rx_udf_set = 1'b0;
      w_sts_clr    = 2'b00;

      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               w_access    = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         S_ACK:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_access) begin
         case (w_off)
            OFF_CTRL: begin
               if (wbs_we_i) begin
                  for (int b = 0; b < 4; b++) begin
                     if (wbs_sel_i[b]) w_ctrl_nxt[8*b +: 8] = wbs_dat_i[8*b +: 8];
                  end
                  // flush is a strobe, never stored
                  w_flush       = wbs_sel_i[0] & wbs_dat_i[2];
                  w_ctrl_nxt[2] = 1'b0;
               end else begin
                  w_rdata_nxt = r_ctrl;
               end
            end
            OFF_STATUS: begin
               if (wbs_we_i) w_sts_clr   = wbs_dat_i[1:0];
               else          w_rdata_nxt = w_status;
            end
            OFF_TXDATA: begin
               if (wbs_we_i) begin
                  w_tx_push    = ~w_tx_full;
                  w_tx_ovf_set = w_tx_full;
               end
            end
            OFF_RXDATA: begin
               if (!wbs_we_i) begin
                  if (w_rx_empty) begin
                     w_rx_udf_set = 1'b1;
                  end else begin
                     w_rx_pop    = 1'b1;
                     w_rdata_nxt = r_rx_mem[r_rx_rp];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Read data, CTRL, sticky flags and interrupt
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_rdata  <= '0;
         r_ctrl   <= '0;
         r_tx_ovf <= 1'b0;
         r_rx_udf <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_rdata  <= w_rdata_nxt;
         r_ctrl   <= w_ctrl_nxt;
         r_tx_ovf <= (r_tx_ovf & ~w_sts_clr[0]) | w_tx_ovf_set;
         r_rx_udf <= (r_rx_udf & ~w_sts_clr[1]) | w_rx_udf_set;
         r_irq    <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & (r_tx_ovf | r_rx_udf));
      end
   end

   // TX FIFO storage
   always_ff @(posedge wb_clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= wbs_dat_i;
   end

   // TX FIFO pointers and count
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else if (w_flush) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
         r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      end
   end

   // RX FIFO storage
   always_ff @(posedge wb_clk_i) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data_i;
   end

   // RX FIFO pointers and count
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else if (w_flush) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
         r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
      end
   end

   assign wbs_ack_o  = (r_state == S_ACK);
   assign wbs_dat_o  = r_rdata;
   assign ctrl_o     = r_ctrl;
   assign irq_o      = r_irq;
   assign tx_valid_o = ~w_tx_empty;
   assign tx_data_o  = r_tx_mem[r_tx_rp];
   assign rx_ready_o = ~w_rx_full;

endmodule

// File: doc/osiris_wb_responder.md
Name: osiris_wb_responder

Overview:
- Wishbone classic slave that terminates the management SoC bus for the osiris_i user project.
- Generates wbs_ack_o and read data, and holds a control register.
- Moves 32-bit words between the bus and the core through two FIFOs: host-to-core (TX) and core-to-host (RX).
- Sits in the user project wrapper between the Caravel Wishbone port and the osiris_i core.

Parameters:
BASE_ADDR, 32'h3000_0000, block base address
ADDR_MASK, 32'hFFFF_FFF0, address bits compared against BASE_ADDR for a hit
FIFO_DEPTH, 8, entries per FIFO; power of two, range 2..128

Ports:
wb_clk_i  input  1  single clock for the whole block
wb_rst_ni  input  1  asynchronous active-low reset
wbs_cyc_i  input  1  bus cycle valid
wbs_stb_i  input  1  strobe
wbs_we_i  input  1  1 = write
wbs_sel_i  input  4  byte lane selects
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  transfer acknowledge
wbs_dat_o  output  32  read data
tx_valid_o  output  1  TX FIFO head valid
tx_data_o  output  32  TX FIFO head word
tx_ready_i  input  1  core accepts head word
rx_valid_i  input  1  core offers a word
rx_data_i  input  32  core word
rx_ready_o  output  1  RX FIFO can accept
ctrl_o  output  32  CTRL register contents
irq_o  output  1  level interrupt

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, ctrl_o=0, both FIFOs empty, sticky flags=0, tx_valid_o=0.
- Hit: cyc & stb & ((adr & ADDR_MASK)==BASE_ADDR). Non-hit cycles are never acked.
- FSM states:
  - IDLE: on hit, perform the access, register read data and go to ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, then return to IDLE.
  - Throughput: ack latency is 1 cycle after stb is sampled. A held stb is re-sampled in IDLE, so at most one ack every 2 cycles and ack is never high on consecutive cycles.
  - The access side effect (push, pop, register write) occurs once per ack.
- wbs_dat_o is valid only while ack=1; it is 0 otherwise.
- Register map, offset adr[3:2]:
  - 0x0 CTRL RW, per byte lane via sel.
    - bit0 rx_irq_en, bit1 err_irq_en.
    - bit2 flush: self-clearing. Writing 1 empties both FIFOs on the access cycle and reads back 0.
    - Other bits are free RW and are driven on ctrl_o.
  - 0x4 STATUS.
    - Read: [0] tx_ovf, [1] rx_udf, [2] tx_full, [3] tx_empty, [4] rx_full, [5] rx_empty, [15:8] tx_count, [23:16] rx_count. Others read 0.
    - Write: write-1-to-clear on bits [1:0]; other bits ignored.
  - 0x8 TXDATA, write pushes wbs_dat_i, ignoring sel.
    - Write when full: word dropped, tx_ovf set, still acked.
    - Read returns 0 with no effect.
  - 0xC RXDATA, read pops the head and returns it.
    - Read when empty: returns 0, sets rx_udf, still acked.
    - Write is acked with no effect.
- TX side: tx_valid_o = !tx_empty and tx_data_o = head word, both driven from registers. Pop on tx_valid_o & tx_ready_i.
- TX simultaneous push and pop: fullness is judged on the pre-cycle state, so a push to a full FIFO is dropped even if a pop happens that cycle. Count is unchanged for push+pop when not full.
- RX side: rx_ready_o = !rx_full. Push on rx_valid_i & rx_ready_o. A simultaneous core push and bus pop on a non-empty FIFO keeps the count.
- Flush has priority over a same-cycle core push/pop.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. Counts are log2(FIFO_DEPTH)+1 bits, zero-extended into 8-bit fields.
- irq_o (registered) = (rx_irq_en & !rx_empty) | (err_irq_en & (tx_ovf | rx_udf)).
- Reset mid-transfer: ack drops asynchronously and the bus transfer is lost. The master must retry.

Test Plan:
1. Write CTRL=0x0000_00A3 with sel=4'b0001 -> ack exactly 1 cycle after stb, CTRL reads 0x0000_00A3, ctrl_o=0x0000_00A3; a second write of 0xFFFF_FF00 with sel=4'b0001 -> CTRL reads 0x0000_0000.
2. Push 8 words 0x11..0x18 to TXDATA with tx_ready_i=0 -> STATUS[2]=1, tx_count=8. 9th write -> tx_ovf=1. Then tx_ready_i=1 -> tx_data_o sequence 0x11..0x18 over 8 cycles, then tx_valid_o=0.
3. Core pushes 0xDEAD_BEEF, 0xCAFE_F00D -> rx_count=2, irq_o=1 when rx_irq_en=1. Two RXDATA reads return those words in order. A third read returns 0, sets rx_udf, and irq_o follows err_irq_en.
4. Write STATUS=0x3 after both sticky flags are set -> STATUS[1:0]=0. Write CTRL bit2=1 with both FIFOs non-empty -> both counts 0 next cycle.
5. Hold stb high for 6 cycles on STATUS -> ack pattern 0,1,0,1,0,1. Address 0x3000_0010 -> no ack ever.
6. Assert wb_rst_ni=0 during the ACK cycle with the FIFOs half full -> ack low immediately, counts 0, ctrl_o=0.
